// File: rtl/vga_pkg.sv
// Shared framebuffer geometry, pixel type and clear-sequencer state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package vga_pkg;

    // Downscale factor as log2: framebuffer pixel = (x>>FB_SHIFT, y>>FB_SHIFT)
    localparam int FB_SHIFT = 2;
    localparam int FB_W     = 640 >> FB_SHIFT;
    localparam int FB_H     = 480 >> FB_SHIFT;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int ADDR_W   = 15;
    localparam int PIX_W    = 12;

    // RGB 4:4:4 pixel
    typedef logic [PIX_W-1:0] pixel_t;

    // Framebuffer word address
    typedef logic [ADDR_W-1:0] fb_addr_t;

    // Clear sequencer states
    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

endpackage

// File: rtl/fb_addr_calc.sv
// Maps a 640x480 screen position to a downscaled framebuffer word address.
// Latency: purely combinational.
// Backpressure: none.
module fb_addr_calc #(
    parameter int FB_SHIFT = vga_pkg::FB_SHIFT,
    parameter int FB_W     = vga_pkg::FB_W,
    parameter int ADDR_W   = vga_pkg::ADDR_W
) (
    input  logic [9:0]        x_i,
    input  logic [9:0]        y_i,
    output logic [ADDR_W-1:0] addr_o
);

    // Downscaled coordinates; full-width shift keeps every input bit in use
    logic [9:0] xx;
    logic [9:0] yy;

    assign xx = x_i >> FB_SHIFT;
    assign yy = y_i >> FB_SHIFT;

    // Row base: for the standard 160-wide buffer the multiply is yy*128 + yy*32,
    // so it folds into two shifted adds instead of a multiplier.
    generate
        if (FB_W == 160) begin : g_shift_add
            assign addr_o = (ADDR_W'(yy) << 7) + (ADDR_W'(yy) << 5) + ADDR_W'(xx);
        end else begin : g_mult
            assign addr_o = (ADDR_W'(yy) * ADDR_W'(FB_W)) + ADDR_W'(xx);
        end
    endgenerate

endmodule

// File: rtl/fb_arbiter.sv
// Schedules a single-port framebuffer RAM between display fetch, clear sequencer and two round-robin writers.
// Latency: p_tick -> mem_addr +1, mem_rdata +2, rgb +3 cycles; writer ready -> mem_we/mem_wdata +1 cycle.
// Backpressure: display fetch preempts all; clear starves writers; writers hold valid until ready.
module fb_arbiter #(
    parameter int FB_SHIFT = vga_pkg::FB_SHIFT,
    parameter int FB_W     = vga_pkg::FB_W,
    parameter int FB_H     = vga_pkg::FB_H,
    parameter int FB_DEPTH = FB_W * FB_H,
    parameter int ADDR_W   = vga_pkg::ADDR_W,
    parameter int PIX_W    = vga_pkg::PIX_W
) (
    input  logic              clock_100,
    input  logic              reset,
    // Timing generator
    input  logic              p_tick,
    input  logic              display_active,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    // Pixel writer 0
    input  logic              wr0_valid,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [PIX_W-1:0]  wr0_data,
    output logic              wr0_ready,
    // Pixel writer 1
    input  logic              wr1_valid,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [PIX_W-1:0]  wr1_data,
    output logic              wr1_ready,
    // Clear sequencer control
    input  logic              clear_start,
    input  logic [PIX_W-1:0]  clear_color,
    output logic              clear_busy,
    // Framebuffer RAM port
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata,
    // DAC side
    output logic [PIX_W-1:0]  rgb,
    output logic              frame_start
);

    import vga_pkg::*;

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(FB_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(FB_DEPTH - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    clr_state_t        clr_state_q;
    logic [ADDR_W-1:0] clr_ptr_q;
    logic [PIX_W-1:0]  clear_color_q;
    logic              clear_busy_q;

    logic              last_q;         // index of the most recently granted writer

    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [PIX_W-1:0]  mem_wdata_q;

    logic [1:0]        pend_tick_q;    // read in flight, stage 0 = address cycle
    logic [1:0]        pend_act_q;     // display_active travelling with that read
    logic [PIX_W-1:0]  rgb_q;
    logic              frame_start_q;

    // ------------------------------------------------------------------
    // Slot decision
    // ------------------------------------------------------------------
    logic              disp_slot;
    logic              clr_slot;
    logic              wr_slot;
    logic              gnt0;
    logic              gnt1;
    logic [ADDR_W-1:0] disp_addr;

    assign disp_slot = p_tick && display_active;
    assign clr_slot  = !disp_slot && clear_busy_q;
    assign wr_slot   = !disp_slot && !clear_busy_q;

    fb_addr_calc #(
        .FB_SHIFT (FB_SHIFT),
        .FB_W     (FB_W),
        .ADDR_W   (ADDR_W)
    ) u_addr_calc (
        .x_i    (x),
        .y_i    (y),
        .addr_o (disp_addr)
    );

    // Round-robin writer grant in whatever cycle neither display nor clear owns the port
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (wr_slot) begin
            if (wr0_valid && wr1_valid) begin
                if (last_q) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else if (wr0_valid) begin
                gnt0 = 1'b1;
            end else if (wr1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    // Ready is held low while reset is asserted so the handshake cannot fire before the block is live
    assign wr0_ready = gnt0 && !reset;
    assign wr1_ready = gnt1 && !reset;

    // Round-robin pointer: starts at 1 so writer 0 wins the first tie
    always_ff @(posedge clock_100 or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (gnt0) begin
            last_q <= 1'b0;
        end else if (gnt1) begin
            last_q <= 1'b1;
        end
    end

    // RAM command register: one access per cycle, address held when idle
    always_ff @(posedge clock_100 or posedge reset) begin
        if (reset) begin
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            if (disp_slot) begin
                mem_addr_q <= disp_addr;
            end else if (clr_slot) begin
                mem_addr_q  <= clr_ptr_q;
                mem_we_q    <= 1'b1;
                mem_wdata_q <= clear_color_q;
            end else if (gnt0) begin
                // Out-of-range writes are acknowledged but dropped
                if (wr0_addr < DEPTH_A) begin
                    mem_addr_q  <= wr0_addr;
                    mem_we_q    <= 1'b1;
                    mem_wdata_q <= wr0_data;
                end
            end else if (gnt1) begin
                if (wr1_addr < DEPTH_A) begin
                    mem_addr_q  <= wr1_addr;
                    mem_we_q    <= 1'b1;
                    mem_wdata_q <= wr1_data;
                end
            end
        end
    end

    // Clear sequencer: walks the whole buffer using only slots the display leaves free
    always_ff @(posedge clock_100 or posedge reset) begin
        if (reset) begin
            clr_state_q   <= CLR_IDLE;
            clr_ptr_q     <= '0;
            clear_color_q <= '0;
            clear_busy_q  <= 1'b0;
        end else begin
            case (clr_state_q)
                CLR_IDLE: begin
                    if (clear_start) begin
                        clear_color_q <= clear_color;
                        clr_ptr_q     <= '0;
                        clear_busy_q  <= 1'b1;
                        clr_state_q   <= CLR_RUN;
                    end
                end
                CLR_RUN: begin
                    // A restart request while running is deliberately ignored
                    if (clr_slot) begin
                        if (clr_ptr_q == LAST_A) begin
                            clear_busy_q <= 1'b0;
                            clr_state_q  <= CLR_IDLE;
                        end else begin
                            clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    clear_busy_q <= 1'b0;
                    clr_state_q  <= CLR_IDLE;
                end
            endcase
        end
    end

    // Display read pipeline: the active flag rides alongside each tick's read, blanking loads zero
    always_ff @(posedge clock_100 or posedge reset) begin
        if (reset) begin
            pend_tick_q   <= '0;
            pend_act_q    <= '0;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            pend_tick_q   <= {pend_tick_q[0], p_tick};
            pend_act_q    <= {pend_act_q[0], display_active};
            if (pend_tick_q[1]) begin
                rgb_q <= pend_act_q[1] ? mem_rdata : '0;
            end
            frame_start_q <= p_tick && (x == 10'd0) && (y == 10'd0);
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
    assign clear_busy  = clear_busy_q;
    assign rgb         = rgb_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural framebuffer RAM and a write scoreboard.
// Latency: checks read path at T+1/T+3 and write path at ready+1.
// Backpressure: writers hold valid until ready, as a real master would.
module tb_fb_arbiter;

    logic        clock_100 = 1'b0;
    logic        reset;
    logic        p_tick;
    logic        display_active;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        wr0_valid;
    logic [14:0] wr0_addr;
    logic [11:0] wr0_data;
    logic        wr0_ready;
    logic        wr1_valid;
    logic [14:0] wr1_addr;
    logic [11:0] wr1_data;
    logic        wr1_ready;
    logic        clear_start;
    logic [11:0] clear_color;
    logic        clear_busy;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic [11:0] rgb;
    logic        frame_start;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [14:0] addr;
        logic [11:0] data;
    } wr_t;

    wr_t exp_q[$];

    always #5 clock_100 = ~clock_100;

    fb_arbiter dut (
        .clock_100      (clock_100),
        .reset          (reset),
        .p_tick         (p_tick),
        .display_active (display_active),
        .x              (x),
        .y              (y),
        .wr0_valid      (wr0_valid),
        .wr0_addr       (wr0_addr),
        .wr0_data       (wr0_data),
        .wr0_ready      (wr0_ready),
        .wr1_valid      (wr1_valid),
        .wr1_addr       (wr1_addr),
        .wr1_data       (wr1_data),
        .wr1_ready      (wr1_ready),
        .clear_start    (clear_start),
        .clear_color    (clear_color),
        .clear_busy     (clear_busy),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .rgb            (rgb),
        .frame_start    (frame_start)
    );

    // Behavioural single-port synchronous RAM, two known words preloaded on the first edge
    logic [11:0] ram [32768] = '{default: 12'h000};
    logic        ram_init = 1'b0;

    always @(posedge clock_100) begin
        if (!ram_init) begin
            ram[0]   <= 12'h123;
            ram[162] <= 12'hF0A;
            ram_init <= 1'b1;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    // Write scoreboard: every issued RAM write must match the next expected entry
    always @(negedge clock_100) begin
        if (!reset && mem_we) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $error("FAIL wr_sb observed addr=%0d data=%h expected no write", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                assert ({mem_addr, mem_wdata} === {e.addr, e.data}) else begin
                    n_err++;
                    $error("FAIL wr_sb observed addr=%0d data=%h expected addr=%0d data=%h",
                           mem_addr, mem_wdata, e.addr, e.data);
                end
            end
        end
    end

    function automatic wr_t mk(input int a, input int d);
        wr_t w;
        w.addr = 15'(a);
        w.data = 12'(d);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_100);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] exp_g [6];
        int         i0;
        int         i1;
        int         cyc;

        reset = 1'b1; p_tick = 1'b0; display_active = 1'b0; x = '0; y = '0;
        wr0_valid = 1'b1; wr0_addr = 15'd5; wr0_data = 12'h111;
        wr1_valid = 1'b0; wr1_addr = '0; wr1_data = '0;
        clear_start = 1'b0; clear_color = '0;
        tick(); tick();

        // Reset state, with a writer requesting to show ready is held off
        chk("rst_rgb",       32'(rgb),         32'd0);
        chk("rst_mem_addr",  32'(mem_addr),    32'd0);
        chk("rst_mem_we",    32'(mem_we),      32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata),   32'd0);
        chk("rst_wr0_ready", 32'(wr0_ready),   32'd0);
        chk("rst_wr1_ready", 32'(wr1_ready),   32'd0);
        chk("rst_busy",      32'(clear_busy),  32'd0);
        chk("rst_fstart",    32'(frame_start), 32'd0);
        wr0_valid = 1'b0;
        reset = 1'b0;
        tick();

        // Pixel (0,0): frame_start pulse and read of word 0
        p_tick = 1'b1; display_active = 1'b1; x = 10'd0; y = 10'd0;
        tick();
        p_tick = 1'b0; x = 10'd1;
        chk("fs_pulse",   32'(frame_start), 32'd1);
        chk("fs_addr",    32'(mem_addr),    32'd0);
        tick();
        chk("fs_clear",   32'(frame_start), 32'd0);
        chk("fs_rgb_t2",  32'(rgb),         32'd0);
        tick();
        chk("fs_rgb_t3",  32'(rgb),         32'h123);

        // Address mapping x=8,y=4 -> 162
        p_tick = 1'b1; display_active = 1'b1; x = 10'd8; y = 10'd4;
        tick();
        p_tick = 1'b0;
        chk("map_addr",   32'(mem_addr), 32'd162);
        chk("map_we",     32'(mem_we),   32'd0);
        tick();
        chk("map_rgb_t2", 32'(rgb), 32'h123);
        tick();
        chk("map_rgb_t3", 32'(rgb), 32'hF0A);

        // Blanking tick: no read, rgb loads zero on the read schedule
        p_tick = 1'b1; display_active = 1'b0; x = 10'd700; y = 10'd10;
        tick();
        p_tick = 1'b0;
        chk("blank_addr",   32'(mem_addr), 32'd162);
        chk("blank_we",     32'(mem_we),   32'd0);
        tick();
        chk("blank_rgb_t2", 32'(rgb), 32'hF0A);
        tick();
        chk("blank_rgb_t3", 32'(rgb), 32'd0);

        // Round-robin between two held writers; cycle 3 is a display slot
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b10, 2'b01};
        i0 = 0; i1 = 0;
        for (int c = 0; c < 6; c++) begin
            wr0_valid = 1'b1; wr0_addr = 15'(10 + i0); wr0_data = 12'(12'h100 + i0);
            wr1_valid = 1'b1; wr1_addr = 15'(20 + i1); wr1_data = 12'(12'h200 + i1);
            p_tick = (c == 3); display_active = (c == 3); x = 10'd8; y = 10'd4;
            #1;
            chk($sformatf("rr_c%0d", c), 32'({wr1_ready, wr0_ready}), 32'(exp_g[c]));
            if (exp_g[c][0]) begin
                exp_q.push_back(mk(10 + i0, 12'h100 + i0));
                i0++;
            end
            if (exp_g[c][1]) begin
                exp_q.push_back(mk(20 + i1, 12'h200 + i1));
                i1++;
            end
            tick();
        end
        wr0_valid = 1'b0; wr1_valid = 1'b0; p_tick = 1'b0; display_active = 1'b0;
        tick(); tick();

        // Out-of-range write: acknowledged, never reaches the RAM
        wr0_valid = 1'b1; wr0_addr = 15'd19200; wr0_data = 12'hFFF;
        #1;
        chk("oor_ready", 32'(wr0_ready), 32'd1);
        tick();
        wr0_valid = 1'b0;
        chk("oor_we", 32'(mem_we), 32'd0);
        tick();

        // Clear with a simultaneous writer: writer wins that cycle, clear follows
        clear_start = 1'b1; clear_color = 12'h00F;
        wr0_valid = 1'b1; wr0_addr = 15'd30; wr0_data = 12'h555;
        #1;
        chk("clr_same_ready", 32'(wr0_ready),  32'd1);
        chk("clr_busy_pre",   32'(clear_busy), 32'd0);
        exp_q.push_back(mk(30, 12'h555));
        for (int a = 0; a < 19200; a++) exp_q.push_back(mk(a, 12'h00F));
        tick();
        clear_start = 1'b0; clear_color = 12'h000;
        wr0_addr = 15'd31; wr0_data = 12'h666;
        chk("clr_busy_rise", 32'(clear_busy), 32'd1);
        cyc = 0;
        while (clear_busy === 1'b1 && cyc < 25000) begin
            clear_start = (cyc == 100);
            if (cyc == 100) clear_color = 12'h0F0;
            #1;
            chk("clr_starve", 32'(wr0_ready), 32'd0);
            tick();
            cyc++;
        end
        chk("clr_len",  32'(cyc),        32'd19200);
        chk("clr_done", 32'(clear_busy), 32'd0);
        #1;
        chk("clr_after_ready", 32'(wr0_ready), 32'd1);
        exp_q.push_back(mk(31, 12'h666));
        tick();
        wr0_valid = 1'b0;
        tick(); tick();
        chk("sb_drain_clear", 32'(exp_q.size()), 32'd0);

        // Cleared colour visible through the display path
        p_tick = 1'b1; display_active = 1'b1; x = 10'd8; y = 10'd4;
        tick();
        p_tick = 1'b0;
        tick(); tick();
        chk("post_clr_rgb", 32'(rgb), 32'h00F);

        // Reset while the clear pointer sits at 5000
        clear_start = 1'b1; clear_color = 12'h0F0;
        for (int a = 0; a < 4999; a++) exp_q.push_back(mk(a, 12'h0F0));
        tick();
        clear_start = 1'b0;
        repeat (5000) tick();
        chk("mid_busy", 32'(clear_busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_rgb",   32'(rgb),        32'd0);
        chk("mid_rst_addr",  32'(mem_addr),   32'd0);
        chk("mid_rst_we",    32'(mem_we),     32'd0);
        chk("mid_rst_wdata", 32'(mem_wdata),  32'd0);
        chk("mid_rst_busy",  32'(clear_busy), 32'd0);
        tick(); tick();
        reset = 1'b0;
        chk("post_rst_busy", 32'(clear_busy), 32'd0);
        chk("sb_drain_mid",  32'(exp_q.size()), 32'd0);
        wr0_valid = 1'b1; wr0_addr = 15'd40; wr0_data = 12'hABC;
        wr1_valid = 1'b1; wr1_addr = 15'd41; wr1_data = 12'hDEF;
        #1;
        chk("post_rst_gnt", 32'({wr1_ready, wr0_ready}), 32'd1);
        exp_q.push_back(mk(40, 12'hABC));
        tick();
        wr0_valid = 1'b0; wr1_valid = 1'b0;
        tick(); tick();
        chk("sb_drain_end", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
